// File: rtl/led_frame_writer.sv
// Double-buffered 8x8 LED frame store: CPU writes the back bank, the scanner reads the front bank,
// and banks swap only at a scan frame boundary. Define LED_FB_COPY_ON_SWAP_EN to refill the back bank after a swap.
module led_frame_writer #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned START = 1,
  parameter int unsigned END   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       swap_done,
  output logic       front_sel,
  input  logic [7:0] scan_addr,
  output logic [7:0] scan_row
);

  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SWAP
`ifdef LED_FB_COPY_ON_SWAP_EN
    , COPY
`endif
  } state_e;

  state_e           state_q;
  logic [7:0]       bank_q [2][ROWS];
  logic             front_sel_q;
  logic             wr_ready_q;
  logic             swap_done_q;
  logic [7:0]       scan_row_q;
  logic [7:0]       prev_addr_q;
`ifdef LED_FB_COPY_ON_SWAP_EN
  logic [IDX_W-1:0] copy_idx_q;
`endif

  logic             scan_in_range_c;
  logic             boundary_c;
  logic             wr_fire_c;
  logic             wr_keep_c;
  logic [IDX_W-1:0] scan_idx_c;
  logic [IDX_W-1:0] wr_idx_c;

  // Address decode and frame-boundary detect (first cycle back at START after leaving it)
  always_comb begin
    scan_in_range_c = (32'(scan_addr) >= START) && (32'(scan_addr) <= END);
    scan_idx_c      = IDX_W'(32'(scan_addr) - START);
    boundary_c      = (32'(scan_addr) == START) && (32'(prev_addr_q) != START);
    wr_fire_c       = wr_valid && wr_ready_q;
    wr_keep_c       = 32'(wr_addr) < ROWS;
    wr_idx_c        = IDX_W'(wr_addr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      swap_done_q <= 1'b0;
      scan_row_q  <= 8'h00;
      prev_addr_q <= 8'(START);
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          bank_q[b][r] <= 8'h00;
        end
      end
`ifdef LED_FB_COPY_ON_SWAP_EN
      copy_idx_q  <= '0;
`endif
    end else begin
      // Scanner read path runs every cycle regardless of FSM state
      prev_addr_q <= scan_addr;
      scan_row_q  <= scan_in_range_c ? bank_q[front_sel_q][scan_idx_c] : 8'h00;
      swap_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          wr_ready_q <= 1'b1;
          if (wr_fire_c && wr_keep_c) begin
            bank_q[~front_sel_q][wr_idx_c] <= wr_data;
          end
          if (commit) begin
            state_q    <= PENDING;
            wr_ready_q <= 1'b0;
          end
        end

        PENDING: begin
          wr_ready_q <= 1'b0;
          if (boundary_c) begin
            state_q <= SWAP;
          end
        end

        SWAP: begin
          front_sel_q <= ~front_sel_q;
          swap_done_q <= 1'b1;
`ifdef LED_FB_COPY_ON_SWAP_EN
          copy_idx_q  <= '0;
          wr_ready_q  <= 1'b0;
          state_q     <= COPY;
`else
          wr_ready_q  <= 1'b1;
          state_q     <= IDLE;
`endif
        end

`ifdef LED_FB_COPY_ON_SWAP_EN
        // front_sel_q already points at the new front bank here
        COPY: begin
          bank_q[~front_sel_q][copy_idx_q] <= bank_q[front_sel_q][copy_idx_q];
          if (32'(copy_idx_q) == ROWS - 1) begin
            wr_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            copy_idx_q <= copy_idx_q + IDX_W'(1);
            wr_ready_q <= 1'b0;
          end
        end
`endif

        default: begin
          wr_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wr_ready  = wr_ready_q;
  assign swap_done = swap_done_q;
  assign front_sel = front_sel_q;
  assign scan_row  = scan_row_q;

endmodule

// File: tb/tb_led_frame_writer.sv
// Scoreboard bench for led_frame_writer: random writes/scans against a two-image frame model.
// Honours LED_FB_COPY_ON_SWAP_EN the same way as the design.
module tb_led_frame_writer;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned START = 1;
  localparam int unsigned END   = 8;
`ifdef LED_FB_COPY_ON_SWAP_EN
  localparam int COPY_CYC = ROWS;
  localparam bit COPY_EN  = 1'b1;
`else
  localparam int COPY_CYC = 0;
  localparam bit COPY_EN  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic       swap_done;
  logic       front_sel;
  logic [7:0] scan_addr;
  logic [7:0] scan_row;

  led_frame_writer #(.ROWS(ROWS), .START(START), .END(END)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit    (commit),
    .swap_done (swap_done),
    .front_sel (front_sel),
    .scan_addr (scan_addr),
    .scan_row  (scan_row)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int sd_cnt = 0;
  int sd_exp = 0;

  // Reference model: displayed image, editable image, displayed bank index
  logic [7:0] front_m [ROWS];
  logic [7:0] back_m  [ROWS];
  bit         fs_m;

  logic [7:0] exp_q [$];
  logic       rd_tag  = 1'b0;
  logic       rd_pend = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_row(input logic [7:0] a);
    if (int'(a) >= int'(START) && int'(a) <= int'(END)) return front_m[int'(a) - int'(START)];
    return 8'h00;
  endfunction

  // Monitor: a read tagged at a sampling edge is compared half a cycle later
  always @(posedge clk) rd_pend <= rd_tag;

  always @(negedge clk) begin
    if (swap_done) sd_cnt++;
    if (rd_pend) begin
      if (exp_q.size() == 0) check("scan_q_underflow", 1, 0);
      else check("scan_row", int'(scan_row), int'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < int'(ROWS); r++) begin
      front_m[r] = 8'h00;
      back_m[r]  = 8'h00;
    end
    fs_m = 1'b0;
  endtask

  // One cycle of stimulus; writes are only issued while the model is idle
  task automatic step(input bit wv, input logic [2:0] a, input logic [7:0] d,
                      input bit cm, input logic [7:0] sa, input bit chk);
    wr_valid  = wv;
    wr_addr   = a;
    wr_data   = d;
    commit    = cm;
    scan_addr = sa;
    rd_tag    = chk;
    if (chk) exp_q.push_back(exp_row(sa));
    if (wv) back_m[a] = d;
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
    rd_tag   = 1'b0;
  endtask

  task automatic sweep();
    for (int i = 0; i < int'(ROWS) + 2; i++) step(1'b0, 3'd0, 8'h00, 1'b0, 8'(int'(START) - 1 + i), 1'b1);
    tick();
    check("swap_pulses", sd_cnt, sd_exp);
  endtask

  task automatic rand_writes(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] sa;
      sa = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 10));
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, sa, 1'b1);
    end
  endtask

  task automatic issue_commit(input bit cw, input bit hold, input logic [2:0] a, input logic [7:0] d);
    check("wr_ready_idle", int'(wr_ready), 1);
    step(cw, 3'($urandom_range(0, 7)), 8'($urandom), 1'b1, 8'd5, 1'b0);
    wr_valid = hold;
    wr_addr  = a;
    wr_data  = d;
    repeat (4) tick();
    check("wr_ready_pending", int'(wr_ready), 0);
    check("front_sel_pending", int'(front_sel), int'(fs_m));
  endtask

  task automatic wait_swap();
    bit ok;
    logic [7:0] t;
    scan_addr = 8'(END);
    tick();
    scan_addr = 8'(START);
    tick();
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (swap_done) ok = 1'b1;
      else tick();
    end
    check("swap_seen", int'(ok), 1);
    if (ok) begin
      sd_exp++;
      fs_m = ~fs_m;
      for (int r = 0; r < int'(ROWS); r++) begin
        t          = front_m[r];
        front_m[r] = back_m[r];
        back_m[r]  = COPY_EN ? front_m[r] : t;
      end
      check("front_sel_swap", int'(front_sel), int'(fs_m));
    end
  endtask

  task automatic finish_swap(input bit hold, input logic [2:0] a, input logic [7:0] d);
    int cnt;
    cnt = 0;
    while (!wr_ready && cnt < 20) begin
      cnt++;
      tick();
    end
    check("busy_after_swap", cnt, COPY_CYC);
    if (hold) begin
      back_m[a] = d;
      tick();
      wr_valid = 1'b0;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wr_ready"}, int'(wr_ready), 0);
    check({tag, "_swap_done"}, int'(swap_done), 0);
    check({tag, "_front_sel"}, int'(front_sel), 0);
    check({tag, "_scan_row"}, int'(scan_row), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hd;
    reset     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = 3'd0;
    wr_data   = 8'h00;
    commit    = 1'b0;
    scan_addr = 8'(START);
    clear_model();
    tick();
    tick();
    reset_checks("rst");
    reset = 1'b1;
    tick();
    check("wr_ready_after_rst", int'(wr_ready), 1);

    // Walking-one rows without commit: scanner still sees the blank front bank
    for (int i = 0; i < int'(ROWS); i++) step(1'b1, 3'(i), 8'(1 << i), 1'b0, 8'(int'(START) + i), 1'b1);
    sweep();

    // Commit and swap at the next wrap
    issue_commit(1'b0, 1'b0, 3'd0, 8'h00);
    wait_swap();
    finish_swap(1'b0, 3'd0, 8'h00);
    sweep();

    // Random edits with out-of-range scans; commit with a write held through PENDING
    rand_writes(12);
    hd = 8'($urandom);
    issue_commit(1'b1, 1'b1, 3'd7, hd);
    wait_swap();
    finish_swap(1'b1, 3'd7, hd);
    sweep();

    // Commit again with no edits: copy keeps the image, otherwise stale contents appear
    issue_commit(1'b0, 1'b0, 3'd0, 8'h00);
    wait_swap();
    finish_swap(1'b0, 3'd0, 8'h00);
    sweep();

    for (int k = 0; k < 3; k++) begin
      rand_writes(10);
      issue_commit(1'($urandom_range(0, 1)), 1'b0, 3'd0, 8'h00);
      wait_swap();
      finish_swap(1'b0, 3'd0, 8'h00);
      sweep();
    end

    // Reset while a commit is pending
    rand_writes(6);
    issue_commit(1'b1, 1'b0, 3'd0, 8'h00);
    reset = 1'b0;
    tick();
    reset_checks("rst_pending");
    reset = 1'b1;
    clear_model();
    tick();
    sweep();

    // Reset a few cycles after a swap (inside the copy window when enabled)
    rand_writes(8);
    issue_commit(1'b0, 1'b0, 3'd0, 8'h00);
    wait_swap();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset_checks("rst_copy");
    reset = 1'b1;
    clear_model();
    tick();
    sweep();

    tick();
    check("scan_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
